// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states and
// the instruction byte layout.
package alu_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned CNT_W   = 3;

  localparam logic [OP_W-1:0] OP_SUM  = 3'h0;
  localparam logic [OP_W-1:0] OP_COMP = 3'h1;
  localparam logic [OP_W-1:0] OP_SL   = 3'h2;
  localparam logic [OP_W-1:0] OP_SR   = 3'h3;
  localparam logic [OP_W-1:0] OP_CMI  = 3'h4;
  localparam logic [OP_W-1:0] OP_CMM  = 3'h5;
  localparam logic [OP_W-1:0] OP_SA   = 3'h6;
  localparam logic [OP_W-1:0] OP_LO   = 3'h7;

  // Instruction byte: [7:5] op, [4:3] rd (also B source), [2:1] ra, [0] nowb
  localparam int unsigned OP_LSB   = 5;
  localparam int unsigned RD_LSB   = 3;
  localparam int unsigned RA_LSB   = 1;
  localparam int unsigned NOWB_BIT = 0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] ra;
    logic              nowb;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_secuenciador_if.sv
// Host-side instruction handshake and completion bus of the ALU sequencer.
interface alu_secuenciador_if;
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               res_valid;
  logic [DATA_W-1:0]  res_data;
  logic [ADDR_W-1:0]  res_addr;

  modport master (output in_valid, in_instr,
                  input  in_ready, res_valid, res_data, res_addr);
  modport slave  (input  in_valid, in_instr,
                  output in_ready, res_valid, res_data, res_addr);
endinterface

// File: rtl/alu_sec_fifo.sv
// Small instruction FIFO placed in front of the sequencer FSM when the
// ALU_SEQ_FIFO_EN build option is enabled. DEPTH must be a power of 2, >= 2.
module alu_sec_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  instr_t din,
  output instr_t dout,
  output logic   empty,
  output logic   full
);
  localparam int unsigned AW = $clog2(DEPTH);

  instr_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty; wrap is natural modulo DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_secuenciador.sv
// Sequences the 4-bit ALU: fetches operands from a 4x4 register file, holds
// ALU inputs stable for ALU_LAT cycles, captures and writes back the result.
// Build option ALU_SEQ_FIFO_EN adds an instruction FIFO in front of the FSM.
module alu_secuenciador
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_secuenciador_if.slave  bus,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [INSTR_W-1:0] alu_instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               busy
);

  if (ALU_LAT < 1 || ALU_LAT > 7 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("alu_secuenciador: illegal ALU_LAT or FIFO_DEPTH");
  end

  state_t             state, state_nxt;
  logic               live;
  logic [DATA_W-1:0]  regs [NREGS];
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OP_W-1:0]    op_q, op_nxt;
  logic [ADDR_W-1:0]  rd_q, rd_nxt;
  logic               nowb_q, nowb_nxt;
  logic [INSTR_W-1:0] alu_instr_nxt;
  logic [DATA_W-1:0]  alu_a_nxt, alu_b_nxt;
  logic               res_valid_nxt;
  logic [DATA_W-1:0]  res_data_nxt;
  logic [ADDR_W-1:0]  res_addr_nxt;

  logic               load;
  instr_t             src;
  logic               wb_we;
  logic [DATA_W-1:0]  a_src, b_src;

  // load: an instruction enters ISSUE this edge; src is where it comes from
`ifdef ALU_SEQ_FIFO_EN
  logic   fifo_empty, fifo_full;
  instr_t fifo_dout;

  alu_sec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid && bus.in_ready),
    .pop   (load),
    .din   (instr_t'(bus.in_instr)),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign load         = (state == ST_IDLE || state == ST_WB) && !fifo_empty;
  assign src          = fifo_dout;
  assign bus.in_ready = live && !fifo_full;
  assign busy         = (state != ST_IDLE) || !fifo_empty;
`else
  assign load         = (state == ST_IDLE) && bus.in_valid && bus.in_ready;
  assign src          = instr_t'(bus.in_instr);
  assign bus.in_ready = live && (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
`endif

  assign wb_we   = (state == ST_WB) && !nowb_q && (op_q != OP_SA);
  // A dequeue during WB must see the value being written back this edge
  assign a_src   = (wb_we && src.ra == rd_q) ? bus.res_data : regs[src.ra];
  assign b_src   = (wb_we && src.rd == rd_q) ? bus.res_data : regs[src.rd];
  assign rd_data = regs[rd_addr];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      live          <= 1'b0;
      cnt           <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      nowb_q        <= 1'b0;
      alu_instr     <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_addr  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state         <= state_nxt;
      live          <= 1'b1;
      cnt           <= cnt_nxt;
      op_q          <= op_nxt;
      rd_q          <= rd_nxt;
      nowb_q        <= nowb_nxt;
      alu_instr     <= alu_instr_nxt;
      alu_a         <= alu_a_nxt;
      alu_b         <= alu_b_nxt;
      bus.res_valid <= res_valid_nxt;
      bus.res_data  <= res_data_nxt;
      bus.res_addr  <= res_addr_nxt;
      // Host load has priority over a write-back to the same register
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (ld_en && ld_addr == ADDR_W'(i))    regs[i] <= ld_data;
        else if (wb_we && rd_q == ADDR_W'(i))  regs[i] <= bus.res_data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == CNT_W'(1)) state_nxt = ST_WB;
      ST_WB:    state_nxt = load ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; ALU inputs are zero outside ISSUE and WAIT
  always_comb begin
    cnt_nxt       = cnt;
    op_nxt        = op_q;
    rd_nxt        = rd_q;
    nowb_nxt      = nowb_q;
    alu_instr_nxt = '0;
    alu_a_nxt     = '0;
    alu_b_nxt     = '0;
    res_valid_nxt = 1'b0;
    res_data_nxt  = bus.res_data;
    res_addr_nxt  = bus.res_addr;

    if (load) begin
      op_nxt        = src.op;
      rd_nxt        = src.rd;
      nowb_nxt      = src.nowb;
      alu_instr_nxt = INSTR_W'(src.op) << OP_LSB;
      alu_a_nxt     = a_src;
      alu_b_nxt     = b_src;
    end else if (state == ST_ISSUE || (state == ST_WAIT && cnt != CNT_W'(1))) begin
      alu_instr_nxt = alu_instr;
      alu_a_nxt     = alu_a;
      alu_b_nxt     = alu_b;
    end

    if (state == ST_ISSUE)     cnt_nxt = CNT_W'(ALU_LAT);
    else if (state == ST_WAIT) cnt_nxt = cnt - CNT_W'(1);

    if (state == ST_WAIT && cnt == CNT_W'(1)) begin
      res_valid_nxt = 1'b1;
      res_data_nxt  = alu_result;
      res_addr_nxt  = rd_q;
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Self-checking bench for alu_secuenciador (default build): directed cases plus
// randomized traffic against a transaction-timeline reference model.
module tb_alu_secuenciador;
  localparam int unsigned ALU_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [7:0] alu_instr;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       busy;

  alu_secuenciador_if bus ();

  alu_secuenciador #(.ALU_LAT(ALU_LAT), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .alu_instr  (alu_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return ~a;
      3'd2:    return a << 1;
      3'd3:    return a >> 1;
      3'd4:    return {3'b000, a == b};
      3'd5:    return {3'b000, a > b};
      3'd6:    return 4'h0;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-in: result is only correct once inputs have been stable ALU_LAT cycles
  logic [3:0] pipe [ALU_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= ref_alu(alu_instr[7:5], alu_a, alu_b);
    for (int i = 1; i < int'(ALU_LAT) - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[ALU_LAT-2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight instruction, tracked by its phase since accept
  logic [3:0] m_regs [4];
  bit         m_live = 0;
  bit         m_busy = 0;
  int         m_phase = 0;
  logic [2:0] m_op;
  logic [1:0] m_rd;
  bit         m_nowb;
  logic [3:0] m_a, m_b, m_res;

  task automatic model_edge();
    logic [3:0] pre [4];
    logic [7:0] ins;
    bit acc;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 4'h0;
      m_live = 0;
      m_busy = 0;
      return;
    end
    pre = m_regs;
    ins = bus.in_instr;
    acc = bus.in_valid && m_live && !m_busy;
    if (m_busy) begin
      m_phase++;
      if (m_phase == int'(ALU_LAT) + 2) begin
        m_busy = 0;
        if (!m_nowb && m_op != 3'd6) m_regs[m_rd] = m_res;
      end
    end
    if (ld_en) m_regs[ld_addr] = ld_data;
    if (acc) begin
      m_busy  = 1;
      m_phase = 0;
      m_op    = ins[7:5];
      m_rd    = ins[4:3];
      m_nowb  = ins[0];
      m_a     = pre[ins[2:1]];
      m_b     = pre[ins[4:3]];
      m_res   = ref_alu(m_op, m_a, m_b);
    end
    m_live = 1;
  endtask

  task automatic check_outputs();
    bit drv, wb;
    drv = m_busy && m_phase <= int'(ALU_LAT);
    wb  = m_busy && m_phase == int'(ALU_LAT) + 1;
    check_eq("in_ready", 8'(bus.in_ready), 8'(m_live && !m_busy));
    check_eq("busy", 8'(busy), 8'(m_busy));
    check_eq("alu_instr", alu_instr, drv ? {m_op, 5'b0} : 8'h00);
    check_eq("alu_a", 8'(alu_a), drv ? 8'(m_a) : 8'h00);
    check_eq("alu_b", 8'(alu_b), drv ? 8'(m_b) : 8'h00);
    check_eq("res_valid", 8'(bus.res_valid), 8'(wb));
    if (wb) begin
      check_eq("res_data", 8'(bus.res_data), 8'(m_res));
      check_eq("res_addr", 8'(bus.res_addr), 8'(m_rd));
    end
    check_eq("rd_data", 8'(rd_data), 8'(m_regs[rd_addr]));
  endtask

  task automatic cycle(input bit v, input logic [7:0] ins, input bit ld,
                       input logic [1:0] la, input logic [3:0] ldd, input bit rst);
    @(negedge clk);
    rst_n        = rst;
    bus.in_valid = v;
    bus.in_instr = ins;
    ld_en        = ld;
    ld_addr      = la;
    ld_data      = ldd;
    rd_addr      = 2'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b1);
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [3:0] d);
    cycle(1'b0, 8'h00, 1'b1, a, d, 1'b1);
  endtask

  task automatic issue(input logic [7:0] ins);
    cycle(1'b1, ins, 1'b0, 2'd0, 4'h0, 1'b1);
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    check_eq(tag, 8'(rd_data), 8'(exp));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 8'h00;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'h0; rd_addr = 2'd0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b0);
    check_eq("rst_ready", 8'(bus.in_ready), 8'h00);

    // R0=3, R1=5; SUM rd=1 ra=0
    load_reg(2'd0, 4'd3);
    load_reg(2'd1, 4'd5);
    issue(8'h08);
    check_eq("issue_a", 8'(alu_a), 8'd3);
    check_eq("issue_b", 8'(alu_b), 8'd5);
    idle(4);
    check_eq("sum_valid", 8'(bus.res_valid), 8'd1);
    check_eq("sum_data", 8'(bus.res_data), 8'd8);
    check_eq("sum_addr", 8'(bus.res_addr), 8'd1);
    idle(3);
    peek("sum_wb", 2'd1, 4'd8);

    // CMI with R2=R3=9 -> 1 into R3
    load_reg(2'd2, 4'd9);
    load_reg(2'd3, 4'd9);
    issue(8'h9C);
    idle(7);
    peek("cmi_wb", 2'd3, 4'd1);

    // CMM with R2=2, R3=9 -> 0 into R3
    load_reg(2'd2, 4'd2);
    load_reg(2'd3, 4'd9);
    issue(8'hBC);
    idle(7);
    peek("cmm_wb", 2'd3, 4'd0);

    // SA and nowb targeting R2 leave it unchanged
    issue(8'hD0);
    idle(7);
    peek("sa_nowr", 2'd2, 4'd2);
    issue(8'h11);
    idle(7);
    peek("nowb_nowr", 2'd2, 4'd2);

    // Host load in the WB cycle to the same register wins
    issue(8'h08);
    idle(4);
    cycle(1'b0, 8'h00, 1'b1, 2'd1, 4'hA, 1'b1);
    idle(2);
    peek("ld_wins", 2'd1, 4'hA);

    // Reset during WAIT aborts the instruction
    issue(8'h08);
    idle(2);
    cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b1);
    check_eq("rdy_after_rst", 8'(bus.in_ready), 8'd1);
    peek("rst_clr", 2'd1, 4'h0);

    // Randomized traffic with occasional WB collisions and resets
    for (int i = 0; i < 2500; i++) begin
      bit         v, ld, rst;
      logic [1:0] la;
      v   = ($urandom % 3) != 0;
      ld  = ($urandom % 4) == 0;
      la  = 2'($urandom);
      rst = ($urandom % 200) != 0;
      if (m_busy && m_phase == int'(ALU_LAT) + 1 && ($urandom % 2) == 0) begin
        ld = 1'b1;
        la = m_rd;
      end
      cycle(v, 8'($urandom), ld, la, 4'($urandom), rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
